// File: rtl/ss_rdfifo.sv
// rtl/ss_rdfifo.sv - FWFT read-data FIFO (64b data + last) for the scatter-gather reader.
// Optional sticky overflow/underflow flag built only when SS_RDFIFO_ERR_EN is defined.
module ss_rdfifo #(
  parameter int AW = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wr_en,
  input  logic [63:0]   wr_dat,
  input  logic          wr_last,
  input  logic          flush,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [63:0]   rd_dat,
  output logic          rd_last,
  output logic          full,
  output logic          fifo_half_empty,
  output logic [AW:0]   count,
  output logic          err
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(1) << AW;
  localparam logic [AW:0] HALF_CNT = (AW+1)'(1) << (AW - 1);

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  // Status comes only from the registered count, never from the strobes.
  assign rd_valid        = (cnt != '0);
  assign full            = (cnt == FULL_CNT);
  assign fifo_half_empty = (cnt <= HALF_CNT);
  assign count           = cnt;
  assign rd_dat          = mem[rd_ptr][63:0];
  assign rd_last         = mem[rd_ptr][64];

  // A read frees the slot the write needs, so a full FIFO still accepts a beat then.
  assign do_rd = rd_valid && rd_ready;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge wb_clk_i) begin
    if (do_wr) begin
      mem[wr_ptr] <= {wr_last, wr_dat};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SS_RDFIFO_ERR_EN
  logic err_q;

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if ((wr_en && full && !do_rd) || (rd_ready && !rd_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ss_rdfifo.sv
// tb/tb_ss_rdfifo.sv - self-checking bench for ss_rdfifo against a queue-based model.
module tb_ss_rdfifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef SS_RDFIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wr_en;
  logic [63:0]   wr_dat;
  logic          wr_last;
  logic          flush;
  logic          rd_valid;
  logic          rd_ready;
  logic [63:0]   rd_dat;
  logic          rd_last;
  logic          full;
  logic          fifo_half_empty;
  logic [AW:0]   count;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  ss_rdfifo #(.AW(AW)) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .wr_en           (wr_en),
    .wr_dat          (wr_dat),
    .wr_last         (wr_last),
    .flush           (flush),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_dat          (rd_dat),
    .rd_last         (rd_last),
    .full            (full),
    .fifo_half_empty (fifo_half_empty),
    .count           (count),
    .err             (err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is a queue of {last, data}.
  logic [64:0] mq[$];
  bit          merr    = 1'b0;
  bit          started = 1'b0;

  always @(posedge wb_clk_i) begin
    bit rd;
    bit drop;
    started = 1'b1;
    if (wb_rst_i) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      rd   = (mq.size() != 0) && rd_ready;
      drop = wr_en && (mq.size() == DEPTH) && !rd;
      if (ERR_EN && (drop || (rd_ready && mq.size() == 0))) merr = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        if (rd) void'(mq.pop_front());
        if (wr_en && !drop) mq.push_back({wr_last, wr_dat});
      end
    end
  end

  always @(negedge wb_clk_i) begin
    if (started) begin
      chk("m_rd_valid", rd_valid, mq.size() != 0);
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_half_empty", fifo_half_empty, mq.size() <= DEPTH / 2);
      chk("m_err", err, merr);
      if (mq.size() != 0) begin
        chk("m_rd_dat", rd_dat, mq[0][63:0]);
        chk("m_rd_last", rd_last, mq[0][64]);
      end
    end
  end

  // Apply one cycle of inputs; returns #1 after the edge that consumed them.
  task automatic cyc(input bit rst, input bit we, input logic [63:0] d, input bit l,
                     input bit fl, input bit rr);
    wb_rst_i = rst; wr_en = we; wr_dat = d; wr_last = l; flush = fl; rd_ready = rr;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0; wr_en = 1'b0; flush = 1'b0; rd_ready = 1'b0; wr_last = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1; wr_en = 1'b0; wr_dat = '0; wr_last = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 64'h5, 0, 1, 1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_half", fifo_half_empty, 1'b1);
    chk("rst_err", err, 1'b0);

    // Single beat, one-cycle latency
    cyc(0, 1, 64'h1111_2222_3333_4444, 0, 0, 0);
    chk("w1_valid", rd_valid, 1'b1);
    chk("w1_dat", rd_dat, 64'h1111_2222_3333_4444);
    chk("w1_count", count, 5'd1);
    chk("w1_half", fifo_half_empty, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("w1_drained", count, 5'd0);

    // Empty write+read: no bypass
    cyc(0, 1, 64'h77, 0, 0, 1);
    chk("nobypass_count", count, 5'd1);
    cyc(0, 0, 0, 0, 0, 1);

    // Fill, overflow, then write+read at full
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 64'h100 + 64'(i), 0, 0, 0);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 5'd16);
    chk("fill_half", fifo_half_empty, 1'b0);
    cyc(0, 1, 64'hDEAD, 0, 0, 0);
    chk("ovf_count", count, 5'd16);
    chk("ovf_head", rd_dat, 64'h100);
    chk("ovf_err", err, ERR_EN);
    cyc(0, 1, 64'hAAAA, 1, 0, 1);
    chk("wr_at_full_count", count, 5'd16);
    chk("wr_at_full_head", rd_dat, 64'h101);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_dat", rd_dat, 64'hAAAA);
    chk("wrap_last", rd_last, 1'b1);
    chk("wrap_count", count, 5'd1);
    cyc(0, 0, 0, 0, 0, 1);

    // Half-empty threshold with a 9-beat buffer
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 64'h900 + 64'(i), i == 8, 0, 0);
    chk("h9_half", fifo_half_empty, 1'b0);
    chk("h9_count", count, 5'd9);
    cyc(0, 0, 0, 0, 0, 1);
    chk("h8_half", fifo_half_empty, 1'b1);
    chk("h8_last", rd_last, 1'b0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("h9th_dat", rd_dat, 64'h908);
    chk("h9th_last", rd_last, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);

    // Flush beats simultaneous write and read
    for (int i = 0; i < 5; i++) cyc(0, 1, 64'h500 + 64'(i), 0, 0, 0);
    cyc(0, 1, 64'hF00, 0, 1, 1);
    chk("flush_count", count, 5'd0);
    chk("flush_valid", rd_valid, 1'b0);
    cyc(0, 1, 64'hBEEF, 0, 0, 0);
    chk("flush_head", rd_dat, 64'hBEEF);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset mid-burst, then underflow
    for (int i = 0; i < 3; i++) cyc(0, 1, 64'h300 + 64'(i), 0, 0, 0);
    cyc(1, 1, 64'h399, 0, 0, 1);
    chk("rst3_count", count, 5'd0);
    chk("rst3_err", err, 1'b0);
    chk("rst3_valid", rd_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("udf_err", err, ERR_EN);
    chk("udf_count", count, 5'd0);
    cyc(0, 1, 64'hC0FFEE, 0, 0, 0);
    chk("post_rst_head", rd_dat, 64'hC0FFEE);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
